aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Top-level control FSM for one AES block encryption. It loads a plaintext, then alternates the add-round-key unit with the round-transform unit (SubBytes/ShiftRows/MixColumns) for NUM_ROUNDS rounds, and holds the intermediate state between operations. It presents a single start/done handshake to the host and owns round numbering for the expanded-key slice select. Expanded-key storage and the round arithmetic sit outside this block.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; round keys used are 0..NUM_ROUNDS; range 1..14.
ARK_LATENCY, 1, cycles from ark_start until ark_result is valid; range 1..7.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to encrypt plaintext; honoured only when ready=1
plaintext  in  128  input block, sampled in the start cycle
ready  out  1  high in IDLE
busy  out  1  high while a block is in flight (not IDLE)
done  out  1  one-cycle pulse; ciphertext valid in that cycle and held after it
ciphertext  out  128  final state
ark_start  out  1  one-cycle pulse to the add-round-key unit
ark_round  out  4  key index for the add-round-key unit
ark_state  out  128  state operand for the add-round-key unit
ark_result  in  128  add-round-key output
rt_start  out  1  one-cycle pulse to the round-transform unit
rt_last  out  1  final round; the transform unit skips MixColumns
rt_state  out  128  state operand for the round-transform unit
rt_result  in  128  round-transform output
rt_finish  in  1  one-cycle pulse; rt_result is valid in that cycle

Behaviour:
- Reset values: ready=1, busy=0, done=0, ciphertext=0, ark_start=0, ark_round=0, rt_start=0, rt_last=0. state_q=0, round_q=0, FSM=IDLE.
- ark_state and rt_state are driven continuously from state_q. ark_round=round_q.
- FSM states: IDLE, ARK_ISSUE, ARK_WAIT, RT_ISSUE, RT_WAIT, DONE.
- IDLE: on start, state_q<=plaintext, round_q<=0, then go to ARK_ISSUE.
- ARK_ISSUE: ark_start=1 for exactly one cycle. Load lat_cnt<=ARK_LATENCY. Go to ARK_WAIT.
- ARK_WAIT: decrement lat_cnt. When lat_cnt reaches 1, state_q<=ark_result.
  - If round_q==NUM_ROUNDS, go to DONE.
  - Otherwise, round_q<=round_q+1 and go to RT_ISSUE.
- The add-round-key finish flag is not a per-operation pulse, so it is not used. Sampling is by fixed latency only.
- RT_ISSUE: rt_start=1 for one cycle. rt_last=(round_q==NUM_ROUNDS), and rt_last is held through RT_WAIT. Go to RT_WAIT.
- RT_WAIT: wait with no timeout. On rt_finish, state_q<=rt_result and go to ARK_ISSUE.
- DONE: ciphertext<=state_q and done=1 for one cycle, then go to IDLE.
- Latency from start to done, with ARK_LATENCY=1 and rt_finish arriving T cycles after rt_start: 3 + (NUM_ROUNDS+1)*2 + NUM_ROUNDS*(T+1) cycles.
- ready=1 only in IDLE, so start is sampled only there. start outside IDLE is ignored; no queueing, no error.
- A start in the same cycle that done pulses is ignored, because the FSM is in DONE, not IDLE.
- rt_finish outside RT_WAIT is ignored.
- ciphertext holds its value until the next DONE.
- round_q never exceeds NUM_ROUNDS. round_q is 4 bits wide, so there is no wrap-around.
- rst mid-operation: all registers return to reset values on the next edge. No done pulse is emitted. The block is ready one cycle after rst deasserts.
- rst asserted together with start: rst wins.

Decomposition:
- Shared package aes_pkg: FSM state enum, AES_BLOCK_W=128, ROUND_W=4, AES128_ROUNDS=10.
- One natural sub-module: aes_latency_timer (loadable down-counter with a terminal-count flag), used in ARK_WAIT.
- Everything else stays inline.

Test Plan:
- FIPS-197 vector: key 000102..0f, plaintext 00112233445566778899aabbccddeeff. Golden models bound to ark/rt, T=1 -> done once, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a. Check the ark_round sequence is 0,1,..,10 and rt_last is high only on the 10th rt_start.
- Back-to-back: start again in the cycle after done -> second block is accepted, and ready=0 for the whole second run.
- start pulsed while busy, in RT_WAIT and in ARK_WAIT -> ignored, and the first ciphertext is unchanged.
- rt_finish delayed by 0..20 random cycles per round -> same ciphertext, and cycle count matches the latency formula.
- rst asserted during round 5 -> next cycle ready=1, busy=0, ciphertext=0, no done. A following encryption gives the correct result.
- NUM_ROUNDS=1, ARK_LATENCY=3 -> exactly two ark_start pulses and one rt_start with rt_last=1. done comes 3+2*4+(T+1) cycles after start.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES block-encryption control path.
// Holds the sequencer state encoding and the fixed AES widths.
`timescale 1ns/1ps
package aes_pkg;

   localparam int AES_BLOCK_W   = 128;
   localparam int ROUND_W       = 4;
   localparam int AES128_ROUNDS = 10;
   localparam int LAT_W         = 3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARK_ISSUE = 3'd1,
      S_ARK_WAIT  = 3'd2,
      S_RT_ISSUE  = 3'd3,
      S_RT_WAIT   = 3'd4,
      S_DONE      = 3'd5
   } seq_state_t;

endpackage

// File: rtl/aes_latency_timer.sv
// Loadable down-counter; tc flags the last cycle of a fixed-latency wait.
`timescale 1ns/1ps
module aes_latency_timer
   import aes_pkg::*;
#(
   parameter int W = LAT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   // A load of N gives N wait cycles, the last one flagged here.
   assign tc = (count_q == W'(1));

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for one AES block: alternates add-round-key and round-transform
// operations, holds the intermediate state and numbers the round keys.
`timescale 1ns/1ps
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS  = AES128_ROUNDS,
   parameter int ARK_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [AES_BLOCK_W-1:0] plaintext,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [AES_BLOCK_W-1:0] ciphertext,
   output logic                   ark_start,
   output logic [ROUND_W-1:0]     ark_round,
   output logic [AES_BLOCK_W-1:0] ark_state,
   input  logic [AES_BLOCK_W-1:0] ark_result,
   output logic                   rt_start,
   output logic                   rt_last,
   output logic [AES_BLOCK_W-1:0] rt_state,
   input  logic [AES_BLOCK_W-1:0] rt_result,
   input  logic                   rt_finish
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
   localparam logic [LAT_W-1:0]   ARK_LAT    = LAT_W'(ARK_LATENCY);

   seq_state_t               fsm_q;
   logic [AES_BLOCK_W-1:0]   state_q;
   logic [ROUND_W-1:0]       round_q;
   logic                     lat_tc;

   aes_latency_timer #(.W(LAT_W)) u_ark_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (fsm_q == S_ARK_ISSUE),
      .load_val (ARK_LAT),
      .en       (fsm_q == S_ARK_WAIT),
      .tc       (lat_tc)
   );

   assign ark_state = state_q;
   assign rt_state  = state_q;
   assign ark_round = round_q;
   assign ready     = (fsm_q == S_IDLE);
   assign busy      = (fsm_q != S_IDLE);

   // Pulse outputs are raised on the edge that enters their state, so each
   // is high exactly while the FSM sits in ARK_ISSUE / RT_ISSUE / DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q      <= S_IDLE;
         state_q    <= '0;
         round_q    <= '0;
         ciphertext <= '0;
         done       <= 1'b0;
         ark_start  <= 1'b0;
         rt_start   <= 1'b0;
         rt_last    <= 1'b0;
      end else begin
         done      <= 1'b0;
         ark_start <= 1'b0;
         rt_start  <= 1'b0;
         case (fsm_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= plaintext;
                  round_q   <= '0;
                  rt_last   <= 1'b0;
                  ark_start <= 1'b1;
                  fsm_q     <= S_ARK_ISSUE;
               end
            end
            S_ARK_ISSUE: fsm_q <= S_ARK_WAIT;
            S_ARK_WAIT: begin
               if (lat_tc) begin
                  state_q <= ark_result;
                  if (round_q == LAST_ROUND) begin
                     // Final key added: publish now so ciphertext is valid with done.
                     ciphertext <= ark_result;
                     done       <= 1'b1;
                     fsm_q      <= S_DONE;
                  end else begin
                     round_q  <= round_q + ROUND_W'(1);
                     rt_start <= 1'b1;
                     rt_last  <= ((round_q + ROUND_W'(1)) == LAST_ROUND);
                     fsm_q    <= S_RT_ISSUE;
                  end
               end
            end
            S_RT_ISSUE: fsm_q <= S_RT_WAIT;
            S_RT_WAIT: begin
               if (rt_finish) begin
                  state_q   <= rt_result;
                  rt_last   <= 1'b0;
                  ark_start <= 1'b1;
                  fsm_q     <= S_ARK_ISSUE;
               end
            end
            S_DONE:  fsm_q <= S_IDLE;
            default: fsm_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES-128 golden units bound to two instances
// (10 rounds / latency 1 and 1 round / latency 3), scoreboard on done.
`timescale 1ns/1ps
module tb_aes_round_sequencer;
   import aes_pkg::*;

   localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT2     = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] PT3     = 128'hffeeddccbbaa99887766554433221100;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- DUT signals ----------------
   logic         a_start, a_ready, a_busy, a_done, a_ark_start, a_rt_start, a_rt_last, a_rt_finish;
   logic [127:0] a_pt, a_ct, a_ark_state, a_ark_result, a_rt_state, a_rt_result;
   logic [3:0]   a_ark_round;
   logic         b_start, b_ready, b_busy, b_done, b_ark_start, b_rt_start, b_rt_last, b_rt_finish;
   logic [127:0] b_pt, b_ct, b_ark_state, b_ark_result, b_rt_state, b_rt_result;
   logic [3:0]   b_ark_round;

   aes_round_sequencer #(.NUM_ROUNDS(10), .ARK_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .plaintext(a_pt), .ready(a_ready), .busy(a_busy),
      .done(a_done), .ciphertext(a_ct), .ark_start(a_ark_start), .ark_round(a_ark_round),
      .ark_state(a_ark_state), .ark_result(a_ark_result), .rt_start(a_rt_start), .rt_last(a_rt_last),
      .rt_state(a_rt_state), .rt_result(a_rt_result), .rt_finish(a_rt_finish)
   );

   aes_round_sequencer #(.NUM_ROUNDS(1), .ARK_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .plaintext(b_pt), .ready(b_ready), .busy(b_busy),
      .done(b_done), .ciphertext(b_ct), .ark_start(b_ark_start), .ark_round(b_ark_round),
      .ark_state(b_ark_state), .ark_result(b_ark_result), .rt_start(b_rt_start), .rt_last(b_rt_last),
      .rt_state(b_rt_state), .rt_result(b_rt_result), .rt_finish(b_rt_finish)
   );

   // ---------------- AES reference ----------------
   logic [7:0]   sbox [256];
   logic [127:0] rk   [16];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // SubBytes + ShiftRows, then MixColumns unless this is the final round.
   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   o [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int q = 0; q < 4; q++) b[4*c+q] = a[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
         if (last) begin
            for (int q = 0; q < 4; q++) o[4*c+q] = b[4*c+q];
         end else begin
            o[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
            o[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
      return r;
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
      logic [127:0] s = pt ^ rk[0];
      for (int r = 1; r <= nr; r++) s = round_fn(s, r == nr) ^ rk[r];
      return s;
   endfunction

   // ---------------- golden ark / rt units ----------------
   // Results read as the inverted value until their latency has elapsed.
   logic [127:0] a_ark_q = '0, a_rt_q = '0, b_ark_q = '0, b_rt_q = '0;
   int           a_ark_cnt = 0, a_rt_cnt = 0, b_ark_cnt = 0, b_rt_cnt = 0;
   logic         a_rt_pend = 1'b0, b_rt_pend = 1'b0;
   int           a_dly_q [$];
   int           b_dly_q [$];

   always @(posedge clk) begin
      if (a_ark_start) begin
         a_ark_q   <= a_ark_state ^ rk[a_ark_round];
         a_ark_cnt <= 0;
      end else if (a_ark_cnt > 0) a_ark_cnt <= a_ark_cnt - 1;
      if (b_ark_start) begin
         b_ark_q   <= b_ark_state ^ rk[b_ark_round];
         b_ark_cnt <= 2;
      end else if (b_ark_cnt > 0) b_ark_cnt <= b_ark_cnt - 1;
   end
   assign a_ark_result = (a_ark_cnt == 0) ? a_ark_q : ~a_ark_q;
   assign b_ark_result = (b_ark_cnt == 0) ? b_ark_q : ~b_ark_q;

   always @(posedge clk) begin
      if (rst) a_rt_pend <= 1'b0;
      else if (a_rt_start) begin
         a_rt_q    <= round_fn(a_rt_state, a_rt_last);
         a_rt_cnt  <= (a_dly_q.size() > 0) ? a_dly_q.pop_front() - 1 : 0;
         a_rt_pend <= 1'b1;
      end else if (a_rt_pend) begin
         if (a_rt_cnt == 0) a_rt_pend <= 1'b0;
         else a_rt_cnt <= a_rt_cnt - 1;
      end
      if (rst) b_rt_pend <= 1'b0;
      else if (b_rt_start) begin
         b_rt_q    <= round_fn(b_rt_state, b_rt_last);
         b_rt_cnt  <= (b_dly_q.size() > 0) ? b_dly_q.pop_front() - 1 : 0;
         b_rt_pend <= 1'b1;
      end else if (b_rt_pend) begin
         if (b_rt_cnt == 0) b_rt_pend <= 1'b0;
         else b_rt_cnt <= b_rt_cnt - 1;
      end
   end
   assign a_rt_finish = a_rt_pend && (a_rt_cnt == 0);
   assign b_rt_finish = b_rt_pend && (b_rt_cnt == 0);
   assign a_rt_result = a_rt_finish ? a_rt_q : ~a_rt_q;
   assign b_rt_result = b_rt_finish ? b_rt_q : ~b_rt_q;

   // ---------------- scoreboard ----------------
   logic [127:0] a_exp_q [$];
   logic [31:0]  a_lat_q [$];
   logic [127:0] b_exp_q [$];
   logic [31:0]  b_lat_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Latency is counted from the start cycle through the cycle after done, inclusive.
   int a_done_cnt = 0, a_start_cyc = 0, a_ark_seen = 0, a_rt_seen = 0, a_bad = 0;
   logic a_inflight = 1'b0;
   initial forever begin
      @(negedge clk);
      if (rst) a_inflight = 1'b0;
      else begin
         if (a_inflight && (a_ready || !a_busy)) a_bad++;
         if (a_start && a_ready) begin
            a_inflight = 1'b1; a_start_cyc = cyc; a_ark_seen = 0; a_rt_seen = 0; a_bad = 0;
         end
         if (a_ark_start) begin
            check("a_ark_round", 128'(a_ark_round), 128'(a_ark_seen));
            a_ark_seen++;
         end
         if (a_rt_start) begin
            a_rt_seen++;
            check("a_rt_last", 128'(a_rt_last), 128'(a_rt_seen == 10));
         end
         if (a_done) begin
            a_done_cnt++;
            if (a_exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL a_unexpected_done: got ciphertext %h, want no done", a_ct);
            end else begin
               check("a_ciphertext", a_ct, a_exp_q.pop_front());
               check("a_latency", 128'(cyc - a_start_cyc + 2), 128'(a_lat_q.pop_front()));
               check("a_ark_count", 128'(a_ark_seen), 128'd11);
               check("a_rt_count", 128'(a_rt_seen), 128'd10);
               check("a_ready_low_in_flight", 128'(a_bad), 128'd0);
            end
            a_inflight = 1'b0;
         end
      end
   end

   int b_done_cnt = 0, b_start_cyc = 0, b_ark_seen = 0, b_rt_seen = 0;
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (b_start && b_ready) begin
            b_start_cyc = cyc; b_ark_seen = 0; b_rt_seen = 0;
         end
         if (b_ark_start) begin
            check("b_ark_round", 128'(b_ark_round), 128'(b_ark_seen));
            b_ark_seen++;
         end
         if (b_rt_start) begin
            b_rt_seen++;
            check("b_rt_last", 128'(b_rt_last), 128'd1);
         end
         if (b_done) begin
            b_done_cnt++;
            if (b_exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL b_unexpected_done: got ciphertext %h, want no done", b_ct);
            end else begin
               check("b_ciphertext", b_ct, b_exp_q.pop_front());
               check("b_latency", 128'(cyc - b_start_cyc + 2), 128'(b_lat_q.pop_front()));
               check("b_ark_count", 128'(b_ark_seen), 128'd2);
               check("b_rt_count", 128'(b_rt_seen), 128'd1);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // fixed_t == 0 picks a random 1..21 cycle rt_finish delay per round.
   task automatic a_issue(input logic [127:0] pt, input logic [127:0] exp_ct, input int fixed_t);
      int lat = 3 + 11 * 2;
      int t;
      #1;
      for (int r = 0; r < 10; r++) begin
         t = (fixed_t != 0) ? fixed_t : int'($urandom_range(1, 21));
         a_dly_q.push_back(t);
         lat += t + 1;
      end
      a_exp_q.push_back(exp_ct);
      a_lat_q.push_back(32'(lat));
      a_pt = pt; a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0; a_pt = '0;
   endtask

   task automatic b_issue(input logic [127:0] pt, input int t);
      #1;
      b_dly_q.push_back(t);
      b_exp_q.push_back(ref_encrypt(pt, 1));
      b_lat_q.push_back(32'(3 + 2 * 4 + t + 1));
      b_pt = pt; b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0; b_pt = '0;
   endtask

   task automatic wait_done(input bit sel_b, input string name);
      int n0 = sel_b ? b_done_cnt : a_done_cnt;
      int k  = 0;
      while (((sel_b ? b_done_cnt : a_done_cnt) == n0) && k < 3000) begin
         @(posedge clk); k++;
      end
      if (k >= 3000) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: got no done in %0d cycles, want done", name, k);
      end
   endtask

   task automatic wait_pulse(input bit want_rt, input string name);
      int k = 0;
      while (!(want_rt ? a_rt_start : a_ark_start) && k < 1000) begin
         @(posedge clk); #1 k++;
      end
      if (k >= 1000) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: got no pulse in %0d cycles, want pulse", name, k);
      end
   endtask

   task automatic busy_start_pulse(input string name);
      check(name, 128'(a_ready), 128'd0);
      a_pt = PT3; a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0; a_pt = '0;
   endtask

   // ---------------- stimulus ----------------
   int k_rst;
   int done_snap;
   initial begin
      rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_pt = '0; b_pt = '0;
      build_sbox();
      expand_key(KEY);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 128'(a_ready), 128'd1);
      check("rst_busy", 128'(a_busy), 128'd0);
      check("rst_done", 128'(a_done), 128'd0);
      check("rst_ciphertext", a_ct, 128'd0);
      check("rst_ark_start", 128'(a_ark_start), 128'd0);
      check("rst_ark_round", 128'(a_ark_round), 128'd0);
      check("rst_rt_start_last", 128'({a_rt_start, a_rt_last}), 128'd0);
      check("rst_state", a_ark_state, 128'd0);
      check("rst_b_ready_busy", 128'({b_ready, b_busy}), 128'd2);
      check("ref_model_fips", ref_encrypt(FIPS_PT, 10), FIPS_CT);
      @(posedge clk); #1 rst = 1'b0;

      // FIPS-197 vector, then a second block started the cycle after done.
      a_issue(FIPS_PT, FIPS_CT, 1);
      wait_done(1'b0, "a_fips");
      a_issue(PT2, ref_encrypt(PT2, 10), 1);
      wait_done(1'b0, "a_back_to_back");

      // start pulsed in RT_WAIT and in ARK_WAIT must be ignored.
      a_issue(FIPS_PT, FIPS_CT, 5);
      wait_pulse(1'b1, "a_rt_start");
      @(posedge clk); #1;
      busy_start_pulse("busy_start_rt_wait_ready");
      wait_pulse(1'b0, "a_ark_start");
      @(posedge clk); #1;
      busy_start_pulse("busy_start_ark_wait_ready");
      wait_done(1'b0, "a_busy_start");
      repeat (5) @(posedge clk);
      #1 check("ciphertext_held", a_ct, FIPS_CT);

      // Random rt_finish delays.
      a_issue(FIPS_PT, FIPS_CT, 0);
      wait_done(1'b0, "a_rand1");
      a_issue(PT3, ref_encrypt(PT3, 10), 0);
      wait_done(1'b0, "a_rand2");

      // Reset while round 5 is in flight.
      a_issue(FIPS_PT, FIPS_CT, 0);
      k_rst = 0;
      while (!(a_ark_start && a_ark_round == 4'd5) && k_rst < 1000) begin
         @(posedge clk); #1 k_rst++;
      end
      check("round5_reached", 128'(k_rst < 1000), 128'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      a_exp_q.delete(); a_lat_q.delete(); a_dly_q.delete();
      check("midrst_ready", 128'(a_ready), 128'd1);
      check("midrst_busy", 128'(a_busy), 128'd0);
      check("midrst_ciphertext", a_ct, 128'd0);
      check("midrst_done", 128'(a_done), 128'd0);
      done_snap = a_done_cnt;
      repeat (40) @(posedge clk);
      #1 check("midrst_no_done", 128'(a_done_cnt), 128'(done_snap));
      a_issue(FIPS_PT, FIPS_CT, 1);
      wait_done(1'b0, "a_after_rst");

      // One round, ARK latency 3.
      b_issue(FIPS_PT, 1);
      wait_done(1'b1, "b_t1");
      b_issue(PT2, 4);
      wait_done(1'b1, "b_t4");

      repeat (5) @(posedge clk);
      #1;
      check("a_queue_drained", 128'(a_exp_q.size()), 128'd0);
      check("b_queue_drained", 128'(b_exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, want finish before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
